// File: rtl/time_set_ctrl.sv
// Time-setting sequencer: mode/add key codes select and adjust hour/min/sec, commit loads the time counter.
// Latency: one cycle, an input sampled at edge k shows on every output after edge k. No backpressure; key codes are consumed every cycle.
// Optional macro FIELD_BLINK_EN: field_blink toggles every BLINK_HALF cycles while editing (otherwise steady 1 in edit).
module time_set_ctrl #(
    parameter int REPEAT_PERIOD = 4,
    parameter int TIMEOUT       = 20,
    parameter int BLINK_HALF    = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] mode_select,
    input  logic [2:0] add_select,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    output logic [4:0] set_hour,
    output logic [5:0] set_min,
    output logic [5:0] set_sec,
    output logic       time_load,
    output logic       run_en,
    output logic [1:0] edit_field,
    output logic       field_blink
);

    localparam int RW = $clog2(REPEAT_PERIOD + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_PERIOD - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    if (REPEAT_PERIOD < 1 || TIMEOUT < 2 || BLINK_HALF < 1) begin : g_param_check
        $error("time_set_ctrl: REPEAT_PERIOD>=1, TIMEOUT>=2, BLINK_HALF>=1 required");
    end

    // Encoding doubles as the edit_field value.
    typedef enum logic [1:0] {
        RUN       = 2'd0,
        EDIT_HOUR = 2'd1,
        EDIT_MIN  = 2'd2,
        EDIT_SEC  = 2'd3
    } state_t;

    function automatic logic [2:0] legal_code(input logic [2:0] c);
        return (c == 3'b001 || c == 3'b010 || c == 3'b100) ? c : 3'b000;
    endfunction

    state_t          state_q, state_d;
    logic [2:0]      mode_code, add_code, mode_prev, add_prev;
    logic            mode_ev, add_ev, add_hold;
    logic            mode_sgl_ev, mode_dbl_ev, mode_long_ev;
    logic            add_ok, add_up, add_dn;
    logic [RW-1:0]   rep_q, rep_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [4:0]      set_hour_d;
    logic [5:0]      set_min_d, set_sec_d;
    logic            time_load_d, run_en_d, field_blink_d;
    logic [1:0]      edit_field_d;

    assign mode_code    = legal_code(mode_select);
    assign add_code     = legal_code(add_select);
    assign mode_ev      = (mode_code != mode_prev) && (mode_code != 3'b000);
    assign add_ev       = (add_code != add_prev) && (add_code != 3'b000);
    assign add_hold     = (add_code == 3'b100);
    assign mode_sgl_ev  = mode_ev && (mode_code == 3'b001);
    assign mode_dbl_ev  = mode_ev && (mode_code == 3'b010);
    assign mode_long_ev = mode_ev && (mode_code == 3'b100);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= RUN;
        else          state_q <= state_d;
    end

    // Next state: commit, abort, timeout, then field advance
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: if (mode_long_ev) state_d = EDIT_HOUR;
            default: begin
                if (mode_dbl_ev || mode_long_ev || tmo_q == TMO_LAST) begin
                    state_d = RUN;
                end else if (mode_sgl_ev) begin
                    case (state_q)
                        EDIT_HOUR: state_d = EDIT_MIN;
                        EDIT_MIN:  state_d = EDIT_SEC;
                        default:   state_d = EDIT_HOUR;
                    endcase
                end
            end
        endcase
    end

    // Add keys only act when no mode event claimed the cycle.
    assign add_ok = (state_q != RUN) && !mode_ev && (state_d == state_q);
    assign add_up = add_ok && ((add_ev && add_code == 3'b001) || (add_hold && rep_q == '0));
    assign add_dn = add_ok && add_ev && (add_code == 3'b010);

    // Outputs and counters
    always_comb begin
        set_hour_d   = set_hour;
        set_min_d    = set_min;
        set_sec_d    = set_sec;
        time_load_d  = (state_q != RUN) && mode_dbl_ev;
        run_en_d     = (state_d == RUN);
        edit_field_d = state_d;

        if (state_q == RUN && mode_long_ev) begin
            set_hour_d = cur_hour;
            set_min_d  = cur_min;
            set_sec_d  = cur_sec;
        end else if (add_up) begin
            case (state_q)
                EDIT_HOUR: set_hour_d = (set_hour == 5'd23) ? 5'd0 : set_hour + 5'd1;
                EDIT_MIN:  set_min_d  = (set_min  == 6'd59) ? 6'd0 : set_min  + 6'd1;
                EDIT_SEC:  set_sec_d  = (set_sec  == 6'd59) ? 6'd0 : set_sec  + 6'd1;
                default: ;
            endcase
        end else if (add_dn) begin
            case (state_q)
                EDIT_HOUR: set_hour_d = (set_hour == 5'd0) ? 5'd23 : set_hour - 5'd1;
                EDIT_MIN:  set_min_d  = (set_min  == 6'd0) ? 6'd59 : set_min  - 6'd1;
                EDIT_SEC:  set_sec_d  = (set_sec  == 6'd0) ? 6'd59 : set_sec  - 6'd1;
                default: ;
            endcase
        end

        if (state_d == RUN || state_d != state_q || !add_hold) rep_d = '0;
        else if (rep_q == REP_LAST)                           rep_d = '0;
        else                                                  rep_d = rep_q + 1'b1;

        if (state_d == RUN || state_q == RUN || mode_ev || add_ev || add_hold) tmo_d = '0;
        else                                                                    tmo_d = tmo_q + 1'b1;
    end

`ifdef FIELD_BLINK_EN
    localparam int BW = $clog2(BLINK_HALF + 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
    logic [BW-1:0] blink_q, blink_d;

    // Any visible edit restarts the blink phase so the new value is shown at once.
    always_comb begin
        blink_d       = '0;
        field_blink_d = field_blink;
        if (state_d == RUN) begin
            field_blink_d = 1'b0;
        end else if (state_d != state_q || add_up || add_dn) begin
            field_blink_d = 1'b1;
        end else if (blink_q == BLINK_LAST) begin
            field_blink_d = ~field_blink;
        end else begin
            blink_d = blink_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) blink_q <= '0;
        else          blink_q <= blink_d;
    end
`else
    assign field_blink_d = (state_d != RUN);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_prev   <= 3'b000;
            add_prev    <= 3'b000;
            rep_q       <= '0;
            tmo_q       <= '0;
            set_hour    <= 5'd0;
            set_min     <= 6'd0;
            set_sec     <= 6'd0;
            time_load   <= 1'b0;
            run_en      <= 1'b1;
            edit_field  <= 2'd0;
            field_blink <= 1'b0;
        end else begin
            mode_prev   <= mode_code;
            add_prev    <= add_code;
            rep_q       <= rep_d;
            tmo_q       <= tmo_d;
            set_hour    <= set_hour_d;
            set_min     <= set_min_d;
            set_sec     <= set_sec_d;
            time_load   <= time_load_d;
            run_en      <= run_en_d;
            edit_field  <= edit_field_d;
            field_blink <= field_blink_d;
        end
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl: entry, add wrap, hold repeat, commit, aborts, reset mid-edit.
module tb_time_set_ctrl;

    logic       clk;
    logic       reset_n;
    logic [2:0] mode_select;
    logic [2:0] add_select;
    logic [4:0] cur_hour;
    logic [5:0] cur_min;
    logic [5:0] cur_sec;
    logic [4:0] set_hour;
    logic [5:0] set_min;
    logic [5:0] set_sec;
    logic       time_load;
    logic       run_en;
    logic [1:0] edit_field;
    logic       field_blink;

    int total = 0;
    int bad   = 0;

    time_set_ctrl dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .mode_select (mode_select),
        .add_select  (add_select),
        .cur_hour    (cur_hour),
        .cur_min     (cur_min),
        .cur_sec     (cur_sec),
        .set_hour    (set_hour),
        .set_min     (set_min),
        .set_sec     (set_sec),
        .time_load   (time_load),
        .run_en      (run_en),
        .edit_field  (edit_field),
        .field_blink (field_blink)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive codes at the falling edge, return at the next falling edge.
    task automatic cyc(input logic [2:0] m, input logic [2:0] a);
        mode_select = m;
        add_select  = a;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_time(input string tag, input int h, input int m, input int s);
        check({tag, ".hour"}, 32'(set_hour), 32'(h));
        check({tag, ".min"},  32'(set_min),  32'(m));
        check({tag, ".sec"},  32'(set_sec),  32'(s));
    endtask

    initial begin
        reset_n = 1'b0; mode_select = 3'b000; add_select = 3'b000;
        cur_hour = 5'd12; cur_min = 6'd34; cur_sec = 6'd56;
        @(negedge clk); @(negedge clk);
        check("rst.run_en", 32'(run_en), 1);
        check("rst.field", 32'(edit_field), 0);
        check("rst.load", 32'(time_load), 0);
        check("rst.blink", 32'(field_blink), 0);
        check_time("rst", 0, 0, 0);
        reset_n = 1'b1;
        cyc(3'b000, 3'b000);

        // Illegal codes and add keys do nothing in RUN.
        cyc(3'b111, 3'b001);
        check("run_ignore.field", 32'(edit_field), 0);
        check_time("run_ignore", 0, 0, 0);

        // Enter edit capturing 12:34:56, then abort with a second long press.
        cyc(3'b100, 3'b000);
        check("enter.field", 32'(edit_field), 1);
        check("enter.run_en", 32'(run_en), 0);
        check("enter.load", 32'(time_load), 0);
        check("enter.blink", 32'(field_blink), 1);
        check_time("enter", 12, 34, 56);
        cyc(3'b000, 3'b000);
        cyc(3'b100, 3'b000);
        check("abort_long.field", 32'(edit_field), 0);
        check("abort_long.run_en", 32'(run_en), 1);
        check("abort_long.load", 32'(time_load), 0);
        check_time("abort_long", 12, 34, 56);
        cyc(3'b000, 3'b000);

        // Hour wrap both ways from 23.
        cur_hour = 5'd23; cur_min = 6'd59; cur_sec = 6'd58;
        cyc(3'b100, 3'b000);
        cyc(3'b000, 3'b000);
        cyc(3'b000, 3'b001);
        check_time("hour_inc_wrap", 0, 59, 58);
        cyc(3'b000, 3'b000);
        cyc(3'b000, 3'b010);
        check_time("hour_dec_wrap", 23, 59, 58);
        cyc(3'b000, 3'b000);

        // Minute field: dec, inc, inc-wrap, dec-wrap.
        cyc(3'b001, 3'b000);
        check("to_min.field", 32'(edit_field), 2);
        cyc(3'b000, 3'b010); cyc(3'b000, 3'b000);
        check("min_dec", 32'(set_min), 58);
        cyc(3'b000, 3'b001); cyc(3'b000, 3'b000);
        cyc(3'b000, 3'b001); cyc(3'b000, 3'b000);
        check("min_inc_wrap", 32'(set_min), 0);
        cyc(3'b000, 3'b010); cyc(3'b000, 3'b000);
        check("min_dec_wrap", 32'(set_min), 59);

        // Seconds: hold add for 9 cycles, steps on cycles 0, 4, 8.
        cyc(3'b001, 3'b000);
        check("to_sec.field", 32'(edit_field), 3);
        for (int i = 1; i <= 9; i++) begin
            cyc(3'b000, 3'b100);
            check($sformatf("hold%0d.sec", i), 32'(set_sec), (i < 5) ? 59 : (i < 9) ? 0 : 1);
        end
        cyc(3'b000, 3'b000);
        check("hold_release.sec", 32'(set_sec), 1);
        check("hold_release.field", 32'(edit_field), 3);

        // Mode and add together: field advances, add dropped.
        cyc(3'b001, 3'b001);
        check("both.field", 32'(edit_field), 1);
        check_time("both", 23, 59, 1);
        cyc(3'b000, 3'b000);
        cyc(3'b001, 3'b000);
        check("to_min2.field", 32'(edit_field), 2);
        cyc(3'b000, 3'b000);

        // Commit from EDIT_MIN: one-cycle load, second double press ignored.
        cyc(3'b010, 3'b000);
        check("commit.load", 32'(time_load), 1);
        check("commit.run_en", 32'(run_en), 1);
        check("commit.field", 32'(edit_field), 0);
        check("commit.blink", 32'(field_blink), 0);
        check_time("commit", 23, 59, 1);
        cyc(3'b000, 3'b000);
        check("commit_after.load", 32'(time_load), 0);
        cyc(3'b010, 3'b000);
        check("dbl_in_run.load", 32'(time_load), 0);
        check("dbl_in_run.field", 32'(edit_field), 0);
        cyc(3'b000, 3'b000);

        // Idle timeout: still editing after 19 idle cycles, back to RUN on the 20th.
        cur_hour = 5'd1; cur_min = 6'd2; cur_sec = 6'd3;
        cyc(3'b100, 3'b000);
        check_time("tmo_enter", 1, 2, 3);
        for (int i = 1; i <= 20; i++) begin
            cyc(3'b000, 3'b000);
            check($sformatf("tmo%0d.field", i), 32'(edit_field), (i < 20) ? 1 : 0);
            check($sformatf("tmo%0d.load", i), 32'(time_load), 0);
        end
        check("tmo.run_en", 32'(run_en), 1);
        check_time("tmo", 1, 2, 3);

        // Asynchronous reset in the middle of an edit.
        cur_hour = 5'd7; cur_min = 6'd8; cur_sec = 6'd9;
        cyc(3'b100, 3'b000);
        cyc(3'b000, 3'b000);
        cyc(3'b000, 3'b001);
        check_time("pre_rst", 8, 8, 9);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst.run_en", 32'(run_en), 1);
        check("mid_rst.field", 32'(edit_field), 0);
        check_time("mid_rst", 0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        cyc(3'b000, 3'b000);
        check("post_rst.load", 32'(time_load), 0);
        check("post_rst.run_en", 32'(run_en), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
- Time-setting sequencer for the digital clock.
- Consumes decoded key codes from two key analysers: the mode key and the add key.
- Selects which time field (hour/min/sec) is being edited and adjusts it; on commit, loads the edited time into the time counter.
- Stops the time counter while editing. Sits between the key analysers and the hour/min/sec counter block.

Parameters:
- REPEAT_PERIOD, 4: cycles between auto-increments while add long-press is held.
- TIMEOUT, 20: idle cycles in any edit state before abort to RUN.
- BLINK_HALF, 8: half-period of field_blink in cycles; used only with FIELD_BLINK_EN.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- mode_select  input  3  mode key code: 001 single (1-cycle pulse), 010 double (1-cycle pulse), 100 long (level while held), 000 none
- add_select  input  3  add key code, same encoding as mode_select
- cur_hour  input  5  running hour, 0..23
- cur_min  input  6  running minute, 0..59
- cur_sec  input  6  running second, 0..59
- set_hour  output  5  edited hour (registered)
- set_min  output  6  edited minute (registered)
- set_sec  output  6  edited second (registered)
- time_load  output  1  one-cycle pulse: counter loads set_*
- run_en  output  1  1 = time counter runs
- edit_field  output  2  0 none, 1 hour, 2 min, 3 sec
- field_blink  output  1  display enable for the field being edited

Behaviour:
- Single clock domain. Reset is asynchronous, active-low.
- Reset values: state RUN, set_* = 0, time_load = 0, run_en = 1, edit_field = 0, field_blink = 0, all counters 0.
- Both code inputs are registered (prev value kept).
- An event is a cycle where code != prev and code != 000. Long-hold is the level add_select == 100.
- States: RUN, EDIT_HOUR, EDIT_MIN, EDIT_SEC. Outputs are registered: an event sampled at edge k is visible after edge k.
- RUN:
  - run_en = 1, edit_field = 0.
  - Mode long event: capture cur_hour/min/sec into set_*, go to EDIT_HOUR, run_en = 0.
  - All add codes are ignored.
- EDIT_* transitions, priority high to low:
  - reset;
  - mode double event: time_load = 1 for exactly one cycle, go to RUN, run_en = 1 from that same edge, set_* held;
  - mode long event: abort, go to RUN, no time_load, set_* retained;
  - timeout counter == TIMEOUT-1: abort as above;
  - mode single event: advance field HOUR -> MIN -> SEC -> HOUR;
  - add activity on the current field.
- Add activity in EDIT_* (only when no mode event in the same cycle; mode events win and the add event is dropped):
  - 001 event: field +1, with wrap 23->0 (hour) and 59->0 (min/sec).
  - 010 event: field -1, with wrap 0->23 (hour) and 0->59 (min/sec).
  - 100 hold: +1 on the entry cycle, then +1 every REPEAT_PERIOD cycles while held. The repeat counter clears when add_select != 100 and on field change.
- Timeout counter:
  - clears on any mode/add event, while add is held at 100, and on entering an edit state;
  - otherwise increments in EDIT_*;
  - held at 0 in RUN.
- Arithmetic is performed in field width with explicit compare-to-max wrap; values never leave range.
- time_load is never asserted in RUN except on the commit transition cycle. Back-to-back commit is impossible: a second double press is seen in RUN and ignored.
- Reset mid-edit: immediate return to RUN with reset values; no load is issued.
- Codes other than 000/001/010/100 are treated as 000.

Optional Feature:
- Macro FIELD_BLINK_EN.
- Defined:
  - field_blink toggles every BLINK_HALF cycles while in EDIT_*.
  - It is forced to 1, with its counter cleared, on edit entry, on field change, and on any add event or repeat step.
  - It is 0 in RUN.
- Undefined: field_blink = 1 in EDIT_* and 0 in RUN. No blink counter is present.

Test Plan:
- Reset, then mode 100 with cur = 12:34:56 -> edit_field = 1, run_en = 0, set_* = 12:34:56, time_load = 0.
- In EDIT_HOUR with set_hour = 23, add 001 pulse -> set_hour = 0. Then add 010 pulse -> set_hour = 23.
- Mode 001 twice -> edit_field = 3. With set_sec = 58, hold add 100 for 9 cycles at REPEAT_PERIOD = 4 -> increments at cycles 0, 4, 8, giving set_sec = 58 -> 59 -> 0 -> 1.
- Mode 010 in EDIT_MIN -> time_load high exactly one cycle, run_en = 1, edit_field = 0, set_* unchanged.
- Enter edit, apply no events for 20 cycles -> back to RUN, no time_load pulse. Repeat with mode 100 inside edit -> same abort.
- Mode 001 and add 001 in the same cycle -> field advances, no value change. Reset asserted mid-edit -> run_en = 1, set_* = 0 immediately (asynchronously).
